// File: rtl/mem_stage.sv
// Memory pipeline stage: IDLE/BUSY handshake with data memory, stalls upstream until dmem_ack.
// Optional stall cycle counter output enabled by defining MEM_STALL_CNT_EN.
module mem_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite_in,
  input  logic              call_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_to_mem_in,
  input  logic [3:0]        reg_rd_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] save_word_data_in,
  input  logic              ret_future_in,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_re,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_out,
`ifdef MEM_STALL_CNT_EN
  output logic [15:0]       stall_cnt_out,
`endif
  output logic              RegWrite_out,
  output logic [3:0]        reg_rd_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              ret_future_out,
  output logic              call_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;
  logic   mem_op;
  logic   rd_op;
  logic   wr_op;

  // A combined load+store request is treated as a store only.
  assign mem_op    = mem_to_reg_in | reg_to_mem_in;
  assign wr_op     = reg_to_mem_in;
  assign rd_op     = mem_to_reg_in & ~reg_to_mem_in;
  assign stall_out = mem_op & ~((state == BUSY) & dmem_ack);

  // Access FSM; strobes, address and data are registered and held until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_re    <= 1'b0;
      dmem_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state      <= BUSY;
            dmem_addr  <= alu_result_in;
            dmem_wdata <= save_word_data_in;
            dmem_re    <= rd_op;
            dmem_we    <= wr_op;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state   <= IDLE;
            dmem_re <= 1'b0;
            dmem_we <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register; a stalled edge emits a bubble and keeps rd/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_out   <= 1'b0;
      reg_rd_out     <= '0;
      wb_data_out    <= '0;
      ret_future_out <= 1'b0;
      call_out       <= 1'b0;
    end else if (!stall_out) begin
      RegWrite_out   <= RegWrite_in;
      reg_rd_out     <= reg_rd_in;
      wb_data_out    <= rd_op ? dmem_rdata : alu_result_in;
      ret_future_out <= ret_future_in;
      call_out       <= call_in;
    end else begin
      RegWrite_out   <= 1'b0;
      ret_future_out <= 1'b0;
      call_out       <= 1'b0;
    end
  end

`ifdef MEM_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_out <= '0;
    end else if (stall_out && (stall_cnt_out != 16'hFFFF)) begin
      stall_cnt_out <= stall_cnt_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset corner cases and
// randomized ops checked against a transaction-level expectation.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        RegWrite_in, call_in, mem_to_reg_in, reg_to_mem_in, ret_future_in;
  logic [3:0]  reg_rd_in;
  logic [15:0] alu_result_in, save_word_data_in;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_re, dmem_we, dmem_ack, stall_out;
  logic        RegWrite_out, ret_future_out, call_out;
  logic [3:0]  reg_rd_out;
  logic [15:0] wb_data_out;
`ifdef MEM_STALL_CNT_EN
  logic [15:0] stall_cnt_out;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0]  last_rd = '0;
  logic [15:0] last_wb = '0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite_in(RegWrite_in), .call_in(call_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_to_mem_in(reg_to_mem_in),
    .reg_rd_in(reg_rd_in), .alu_result_in(alu_result_in),
    .save_word_data_in(save_word_data_in), .ret_future_in(ret_future_in),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_re(dmem_re), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_out(stall_out),
`ifdef MEM_STALL_CNT_EN
    .stall_cnt_out(stall_cnt_out),
`endif
    .RegWrite_out(RegWrite_out), .reg_rd_out(reg_rd_out),
    .wb_data_out(wb_data_out), .ret_future_out(ret_future_out),
    .call_out(call_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, actual running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".bub_regwrite"}, RegWrite_out, 1'b0);
    chk({tag, ".bub_call"}, call_out, 1'b0);
    chk({tag, ".bub_retf"}, ret_future_out, 1'b0);
    chk({tag, ".bub_rd_hold"}, reg_rd_out, last_rd);
    chk({tag, ".bub_wb_hold"}, wb_data_out, last_wb);
  endtask

  task automatic drive(input logic rw, input logic cl, input logic ld, input logic st,
                       input logic [3:0] rd, input logic [15:0] alu, input logic [15:0] sw,
                       input logic rf);
    RegWrite_in = rw; call_in = cl; mem_to_reg_in = ld; reg_to_mem_in = st;
    reg_rd_in = rd; alu_result_in = alu; save_word_data_in = sw; ret_future_in = rf;
  endtask

  // Called at a negedge; returns at a negedge after the op has retired.
  task automatic run_op(input string tag, input logic rw, input logic cl, input logic ld,
                        input logic st, input logic [3:0] rd, input logic [15:0] alu,
                        input logic [15:0] sw, input logic rf, input int lat,
                        input logic [15:0] rdata, input logic [15:0] exp_wb);
    logic mem;
    mem = ld | st;
    drive(rw, cl, ld, st, rd, alu, sw, rf);
    dmem_ack = 1'b0;
    dmem_rdata = rdata;
    #1;
    chk({tag, ".stall_first"}, stall_out, mem);
    if (mem) begin
      @(posedge clk); @(negedge clk);
      chk_bubble(tag);
      for (int c = 1; c <= lat; c++) begin
        chk({tag, ".re"}, dmem_re, ld & ~st);
        chk({tag, ".we"}, dmem_we, st);
        chk({tag, ".addr"}, dmem_addr, alu);
        chk({tag, ".wdata"}, dmem_wdata, sw);
        if (c == lat) begin
          dmem_ack = 1'b1;
          #1 chk({tag, ".stall_ack"}, stall_out, 1'b0);
        end else begin
          #1 chk({tag, ".stall_wait"}, stall_out, 1'b1);
        end
        @(posedge clk); @(negedge clk);
        if (c != lat) chk_bubble(tag);
      end
      dmem_ack = 1'b0;
    end else begin
      chk({tag, ".idle_re"}, dmem_re, 1'b0);
      chk({tag, ".idle_we"}, dmem_we, 1'b0);
      @(posedge clk); @(negedge clk);
    end
    chk({tag, ".regwrite"}, RegWrite_out, rw);
    chk({tag, ".rd"}, reg_rd_out, rd);
    chk({tag, ".wb"}, wb_data_out, exp_wb);
    chk({tag, ".call"}, call_out, cl);
    chk({tag, ".retf"}, ret_future_out, rf);
    chk({tag, ".re_done"}, dmem_re, 1'b0);
    chk({tag, ".we_done"}, dmem_we, 1'b0);
    last_rd = rd;
    last_wb = exp_wb;
  endtask

  typedef struct {
    string       name;
    logic        rw, cl, ld, st;
    logic [3:0]  rd;
    logic [15:0] alu, sw;
    logic        rf;
    int          lat;
    logic [15:0] rdata, exp_wb;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"alu_1234", 1, 0, 0, 0, 4'd5, 16'h1234, 16'h0000, 0, 1, 16'h0000, 16'h1234};
    vecs[1] = '{"load_beef", 1, 0, 1, 0, 4'd3, 16'h0040, 16'h0000, 0, 3, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{"call_store", 0, 1, 0, 1, 4'd0, 16'hFFFE, 16'h0102, 0, 2, 16'h9999, 16'hFFFE};
    vecs[3] = '{"ld_and_st", 1, 0, 1, 1, 4'd7, 16'h00A0, 16'h5555, 0, 1, 16'hDEAD, 16'h00A0};
    vecs[4] = '{"load_min", 1, 0, 1, 0, 4'd2, 16'h0010, 16'h0000, 1, 1, 16'h7777, 16'h7777};
    vecs[5] = '{"alu_retf", 0, 0, 0, 0, 4'hF, 16'hAAAA, 16'h0000, 1, 1, 16'h0000, 16'hAAAA};
    vecs[6] = '{"alu_pre_rst", 1, 0, 0, 0, 4'hC, 16'h5A5A, 16'h0000, 0, 1, 16'h0000, 16'h5A5A};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 0);
    dmem_ack = 1'b0;
    dmem_rdata = 16'h0;
    #3;
    chk("rst.re", dmem_re, 1'b0);
    chk("rst.we", dmem_we, 1'b0);
    chk("rst.addr", dmem_addr, 16'h0);
    chk("rst.wdata", dmem_wdata, 16'h0);
    chk("rst.regwrite", RegWrite_out, 1'b0);
    chk("rst.wb", wb_data_out, 16'h0);
    chk("rst.rd", reg_rd_out, 4'h0);
`ifdef MEM_STALL_CNT_EN
    chk("rst.cnt", stall_cnt_out, 16'h0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].name, vecs[i].rw, vecs[i].cl, vecs[i].ld, vecs[i].st, vecs[i].rd,
             vecs[i].alu, vecs[i].sw, vecs[i].rf, vecs[i].lat, vecs[i].rdata, vecs[i].exp_wb);

    // Asynchronous reset in the middle of a load.
    drive(1, 0, 1, 0, 4'd9, 16'h0300, 16'h0000, 0);
    @(posedge clk); @(negedge clk);
    chk("rstmid.busy_re", dmem_re, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.re", dmem_re, 1'b0);
    chk("rstmid.addr", dmem_addr, 16'h0);
    chk("rstmid.regwrite", RegWrite_out, 1'b0);
    chk("rstmid.rd", reg_rd_out, 4'h0);
    chk("rstmid.wb", wb_data_out, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    last_wb = '0;
    dmem_ack = 1'b1;
    #1 chk("rstmid.stray_ack_stall", stall_out, 1'b1);
    @(posedge clk); @(negedge clk);
    dmem_ack = 1'b0;
    chk("rstmid.reentry_re", dmem_re, 1'b1);
    chk("rstmid.reentry_bubble", RegWrite_out, 1'b0);
    dmem_rdata = 16'h1111;
    dmem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_ack = 1'b0;
    chk("rstmid.done_wb", wb_data_out, 16'h1111);
    chk("rstmid.done_rd", reg_rd_out, 4'd9);
    last_rd = 4'd9;
    last_wb = 16'h1111;

    // Stray ack while idle with no memory request.
    drive(1, 0, 0, 0, 4'd4, 16'h0BAD, 16'h0000, 0);
    dmem_ack = 1'b1;
    #1 chk("idle_ack.stall", stall_out, 1'b0);
    @(posedge clk); @(negedge clk);
    dmem_ack = 1'b0;
    chk("idle_ack.re", dmem_re, 1'b0);
    chk("idle_ack.we", dmem_we, 1'b0);
    chk("idle_ack.wb", wb_data_out, 16'h0BAD);
    last_rd = 4'd4;
    last_wb = 16'h0BAD;

    // Randomized ops; the expectation follows directly from the op type.
    for (int i = 0; i < 150; i++) begin
      logic        rw, cl, ld, st, rf;
      logic [3:0]  rd;
      logic [15:0] alu, sw, rdata, exp_wb;
      int          lat;
      rw = 1'($urandom); cl = 1'($urandom); rf = 1'($urandom);
      ld = ($urandom_range(0, 2) == 0); st = ($urandom_range(0, 2) == 0);
      rd = 4'($urandom); alu = 16'($urandom); sw = 16'($urandom); rdata = 16'($urandom);
      lat = $urandom_range(1, 4);
      exp_wb = (ld && !st) ? rdata : alu;
      run_op("rand", rw, cl, ld, st, rd, alu, sw, rf, lat, rdata, exp_wb);
    end

`ifdef MEM_STALL_CNT_EN
    rst_n = 1'b0;
    #1 chk("cnt.reset", stall_cnt_out, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 4'd0, 16'h0100, 16'h0001, 0);
    @(posedge clk); @(negedge clk);
    chk("cnt.first", stall_cnt_out, 16'h1);
    repeat (70000) @(negedge clk);
    chk("cnt.saturate", stall_cnt_out, 16'hFFFF);
    dmem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    dmem_ack = 1'b0;
    chk("cnt.hold_sat", stall_cnt_out, 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
